id_ex_stage: RTL

- ID/EX pipeline register and operand-select stage of the 5-stage MIPS pipeline; sits directly upstream of the ALU and drives its data1, data2 and aluoperation inputs.
- Captures decoded instruction fields each cycle.
- Resolves RAW hazards by forwarding from EX/MEM and MEM/WB.
- Detects load-use hazards, stalls IF/ID and inserts one bubble.
- Flushes on taken branch.
- Keeps a saturating stall counter for performance debug.

---
 rtl/mips_pkg.sv | 21 ++
 rtl/id_ex_stage_fwd_unit.sv | 38 +++
 rtl/id_ex_stage.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS pipeline constants: datapath widths, ALU op codes, forwarding selects.
package mips_pkg;

   localparam int unsigned DW = 32;
   localparam int unsigned RW = 5;

   localparam logic [3:0] ALU_ADD = 4'b0000;
   localparam logic [3:0] ALU_SUB = 4'b0001;
   localparam logic [3:0] ALU_AND = 4'b0010;
   localparam logic [3:0] ALU_OR  = 4'b0011;
   localparam logic [3:0] ALU_XOR = 4'b0100;
   localparam logic [3:0] ALU_BEQ = 4'b0101;
   localparam logic [3:0] ALU_BNE = 4'b0110;
   localparam logic [3:0] ALU_SLT = 4'b0111;
   localparam logic [3:0] ALU_SLL = 4'b1000;

   localparam logic [1:0] FWD_REG   = 2'b00;
   localparam logic [1:0] FWD_MEMWB = 2'b01;
   localparam logic [1:0] FWD_EXMEM = 2'b10;

endpackage

// File: rtl/id_ex_stage_fwd_unit.sv
// Per-operand forwarding selector: EX/MEM beats MEM/WB beats the register value; r0 never forwards.
module fwd_unit
   import mips_pkg::*;
#(
   parameter int unsigned DW = mips_pkg::DW,
   parameter int unsigned RW = mips_pkg::RW
) (
   input  logic [RW-1:0] src,
   input  logic [DW-1:0] reg_data,
   input  logic          exmem_regwrite,
   input  logic [RW-1:0] exmem_rd,
   input  logic [DW-1:0] exmem_result,
   input  logic          memwb_regwrite,
   input  logic [RW-1:0] memwb_rd,
   input  logic [DW-1:0] memwb_data,
   output logic [1:0]    sel_c,
   output logic [DW-1:0] data_c
);

   logic exmem_hit;
   logic memwb_hit;

   assign exmem_hit = exmem_regwrite && (exmem_rd != '0) && (exmem_rd == src);
   assign memwb_hit = memwb_regwrite && (memwb_rd != '0) && (memwb_rd == src);

   always_comb begin
      sel_c  = FWD_REG;
      data_c = reg_data;
      if (exmem_hit) begin
         sel_c  = FWD_EXMEM;
         data_c = exmem_result;
      end else if (memwb_hit) begin
         sel_c  = FWD_MEMWB;
         data_c = memwb_data;
      end
   end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall, flush bubble, operand forwarding and stall counter.
module id_ex_stage
   import mips_pkg::*;
#(
   parameter int unsigned DW = mips_pkg::DW,
   parameter int unsigned RW = mips_pkg::RW,
   parameter int unsigned CW = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          id_valid,
   input  logic [RW-1:0] id_rs,
   input  logic [RW-1:0] id_rt,
   input  logic [RW-1:0] id_rd,
   input  logic [DW-1:0] id_rs_data,
   input  logic [DW-1:0] id_rt_data,
   input  logic [DW-1:0] id_imm,
   input  logic [3:0]    id_aluop,
   input  logic          id_alusrc,
   input  logic          id_uses_rt,
   input  logic          id_memread,
   input  logic          id_memwrite,
   input  logic          id_regwrite,
   input  logic          exmem_regwrite,
   input  logic [RW-1:0] exmem_rd,
   input  logic [DW-1:0] exmem_result,
   input  logic          memwb_regwrite,
   input  logic [RW-1:0] memwb_rd,
   input  logic [DW-1:0] memwb_data,
   input  logic          flush,
   output logic          stall,
   output logic          ex_valid,
   output logic [DW-1:0] ex_data1,
   output logic [DW-1:0] ex_data2,
   output logic [3:0]    ex_aluop,
   output logic [DW-1:0] ex_store_data,
   output logic [RW-1:0] ex_rd,
   output logic          ex_memread,
   output logic          ex_memwrite,
   output logic          ex_regwrite,
   output logic [CW-1:0] stall_count
);

   logic [RW-1:0] rs_q;
   logic [RW-1:0] rt_q;
   logic [DW-1:0] rs_data_q;
   logic [DW-1:0] rt_data_q;
   logic [DW-1:0] imm_q;
   logic          alusrc_q;

   logic [1:0]    rs_sel;
   logic [1:0]    rt_sel;
   logic [DW-1:0] rs_fwd;
   logic [DW-1:0] rt_fwd;
   logic          src_match;

   // Load-use: the instruction in ID reads the register a load in EX is about to produce
   assign src_match = (id_rs == ex_rd) || (id_uses_rt && (id_rt == ex_rd));
   assign stall     = !flush && id_valid && ex_valid && ex_memread
                      && (ex_rd != '0) && src_match;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ex_valid    <= 1'b0;
         ex_memread  <= 1'b0;
         ex_memwrite <= 1'b0;
         ex_regwrite <= 1'b0;
         ex_rd       <= '0;
         ex_aluop    <= ALU_ADD;
         rs_q        <= '0;
         rt_q        <= '0;
         rs_data_q   <= '0;
         rt_data_q   <= '0;
         imm_q       <= '0;
         alusrc_q    <= 1'b0;
      end else begin
         // Data fields always follow ID; a bubble only has to kill the control bits
         rs_q      <= id_rs;
         rt_q      <= id_rt;
         rs_data_q <= id_rs_data;
         rt_data_q <= id_rt_data;
         imm_q     <= id_imm;
         alusrc_q  <= id_alusrc;
         ex_aluop  <= id_aluop;
         if (flush || stall) begin
            ex_valid    <= 1'b0;
            ex_memread  <= 1'b0;
            ex_memwrite <= 1'b0;
            ex_regwrite <= 1'b0;
            ex_rd       <= '0;
         end else begin
            ex_valid    <= id_valid;
            ex_memread  <= id_valid && id_memread;
            ex_memwrite <= id_valid && id_memwrite;
            ex_regwrite <= id_valid && id_regwrite;
            ex_rd       <= id_rd;
         end
      end
   end

   // Saturating debug counter of stall cycles
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         stall_count <= '0;
      end else if (stall && (stall_count != '1)) begin
         stall_count <= stall_count + CW'(1);
      end
   end

   fwd_unit #(.DW(DW), .RW(RW)) u_fwd_rs (
      .src            (rs_q),
      .reg_data       (rs_data_q),
      .exmem_regwrite (exmem_regwrite),
      .exmem_rd       (exmem_rd),
      .exmem_result   (exmem_result),
      .memwb_regwrite (memwb_regwrite),
      .memwb_rd       (memwb_rd),
      .memwb_data     (memwb_data),
      .sel_c          (rs_sel),
      .data_c         (rs_fwd)
   );

   fwd_unit #(.DW(DW), .RW(RW)) u_fwd_rt (
      .src            (rt_q),
      .reg_data       (rt_data_q),
      .exmem_regwrite (exmem_regwrite),
      .exmem_rd       (exmem_rd),
      .exmem_result   (exmem_result),
      .memwb_regwrite (memwb_regwrite),
      .memwb_rd       (memwb_rd),
      .memwb_data     (memwb_data),
      .sel_c          (rt_sel),
      .data_c         (rt_fwd)
   );

   // Unforwarded operands come straight from the pipeline register
   assign ex_data1      = (rs_sel == FWD_REG) ? rs_data_q : rs_fwd;
   assign ex_store_data = (rt_sel == FWD_REG) ? rt_data_q : rt_fwd;
   assign ex_data2      = alusrc_q ? imm_q : ex_store_data;

endmodule
